// File: rtl/v_pkg.sv
// ---------------------------------------------------------------------------
// v_pkg
// Types shared across the list update path.
//   id_t / cmd_t / key_t / size_t : the fields carried on the list update bus
//   upd_t                         : one update command. It is used both as a
//                                   FIFO entry and as the registered bus bundle.
//   cmd_is_legal()                : returns 1 only for the defined command
//                                   encodings.
// ---------------------------------------------------------------------------
package v_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  size_t;

  // Command encodings that have a meaning to the list engine. Encoding 0 and
  // encodings 5..7 are undefined. They are dropped before they reach the bus.
  typedef enum logic [2:0] {
    CMD_INSERT = 3'd1,
    CMD_DELETE = 3'd2,
    CMD_MODIFY = 3'd3,
    CMD_FLUSH  = 3'd4
  } cmd_t;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_t;

  function automatic logic cmd_is_legal(input cmd_t cmd);
    case (cmd)
      CMD_INSERT,
      CMD_DELETE,
      CMD_MODIFY,
      CMD_FLUSH: cmd_is_legal = 1'b1;
      default:   cmd_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/v_upd_fifo.sv
// ---------------------------------------------------------------------------
// v_upd_fifo
// Synchronous FIFO of upd_t entries with an asynchronous active-low reset.
// DEPTH must be a power of two so that the pointers wrap by plain overflow.
//
// Ports
//   clk, rst_n   clock and async active-low reset
//   push         write push_data at the tail. It is ignored while full.
//   push_data    entry to be written
//   pop          discard the head entry. It is ignored while empty.
//   head_data    current head entry. It is valid when empty is low.
//   count        registered occupancy, 0..DEPTH
//   full, empty  decoded from the registered count
// ---------------------------------------------------------------------------
module v_upd_fifo
  import v_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  upd_t                       push_data,
  input  logic                       pop,
  output upd_t                       head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  upd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard both operations here. A caller that asserts push while full, or
  // pop while empty, cannot corrupt the pointers or the count.
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop  & ~empty;
  end

  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    head_data = mem[rd_ptr];
  end

  // The storage is cleared on reset as well. After a reset the head data
  // (and so the bus fields) is never a leftover from before the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A push and a pop in the same cycle leave the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/v_upd_issue.sv
// ---------------------------------------------------------------------------
// v_upd_issue
// Transmitter end of the list update bus. Upstream commands arrive over a
// valid/ready handshake. Legal commands are buffered in a FIFO. They are
// then issued, one per cycle and in arrival order, onto the registered list
// update bus. Issue is held off while the list engine reports busy. Illegal
// commands complete their handshake but are discarded and counted.
//
// Ports
//   clk, rst_n          clock and async active-low reset
//   i_in_vld / o_in_rdy upstream handshake. Ready is low only when the FIFO
//                       is full.
//   i_in_prod_id/cmd/key/size  upstream command fields
//   i_busy_r            engine busy (initialising). Nothing issues while it
//                       is high.
//   o_upd_vld_r         update bus valid, registered
//   o_upd_prod_id_r/cmd_r/key_r/size_r  update bus fields. They hold their
//                       value when valid is low.
//   o_count_r           FIFO occupancy
//   o_issued_cnt_r      commands issued, saturating
//   o_reject_cnt_r      illegal commands discarded, saturating
// ---------------------------------------------------------------------------
module v_upd_issue
  import v_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_in_vld,
  output logic                            o_in_rdy,
  input  logic [$bits(id_t)-1:0]          i_in_prod_id,
  input  logic [$bits(cmd_t)-1:0]         i_in_cmd,
  input  logic [$bits(key_t)-1:0]         i_in_key,
  input  logic [$bits(size_t)-1:0]        i_in_size,
  input  logic                            i_busy_r,
  output logic                            o_upd_vld_r,
  output logic [$bits(id_t)-1:0]          o_upd_prod_id_r,
  output logic [$bits(cmd_t)-1:0]         o_upd_cmd_r,
  output logic [$bits(key_t)-1:0]         o_upd_key_r,
  output logic [$bits(size_t)-1:0]        o_upd_size_r,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count_r,
  output logic [CNT_W-1:0]                o_issued_cnt_r,
  output logic [CNT_W-1:0]                o_reject_cnt_r
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  upd_t          in_entry;
  logic          in_legal;
  logic          in_fire;
  logic          push;
  logic          reject;
  logic          issue;
  upd_t          head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  upd_t          upd_r;
  logic          upd_vld_r;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] reject_cnt;

  // Bundle the upstream fields into one entry and classify the command.
  always_comb begin
    in_entry.prod_id = i_in_prod_id;
    in_entry.cmd     = cmd_t'(i_in_cmd);
    in_entry.key     = i_in_key;
    in_entry.size    = i_in_size;
    in_legal         = cmd_is_legal(cmd_t'(i_in_cmd));
  end

  // Ready depends only on the registered count. A pop in the same cycle
  // does not free a slot for this cycle's handshake, so nothing writes
  // through while the FIFO is full. An illegal command still completes its
  // handshake so that upstream is never stalled by it.
  always_comb begin
    o_in_rdy = ~full;
    in_fire  = i_in_vld & o_in_rdy;
    push     = in_fire & in_legal;
    reject   = in_fire & ~in_legal;
  end

  // Busy is looked at only in the cycle that decides to issue. A command
  // that is already on the bus when busy rises is left there and is
  // counted as issued.
  always_comb begin
    issue = ~empty & ~i_busy_r;
  end

  v_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_entry),
    .pop       (issue),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Issue register. The data fields load only on issue, so they keep the
  // last issued command while valid is low. There is no bypass from the
  // input, so the minimum input-to-bus latency is two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_vld_r <= 1'b0;
      upd_r     <= '0;
    end else begin
      upd_vld_r <= issue;
      if (issue) begin
        upd_r <= head;
      end
    end
  end

  // Statistics. Both counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      reject_cnt <= '0;
    end else begin
      if (issue && (issued_cnt != '1)) begin
        issued_cnt <= issued_cnt + 1'b1;
      end
      if (reject && (reject_cnt != '1)) begin
        reject_cnt <= reject_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_upd_vld_r     = upd_vld_r;
    o_upd_prod_id_r = upd_r.prod_id;
    o_upd_cmd_r     = upd_r.cmd;
    o_upd_key_r     = upd_r.key;
    o_upd_size_r    = upd_r.size;
    o_count_r       = count;
    o_issued_cnt_r  = issued_cnt;
    o_reject_cnt_r  = reject_cnt;
  end

endmodule

// File: tb/tb_v_upd_issue.sv
// ---------------------------------------------------------------------------
// tb_v_upd_issue
// Bench for the list update transmitter. Two instances share one stimulus
// stream: one has 16-bit statistics counters and one has 4-bit counters.
// The expected bus traffic comes from a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_v_upd_issue;
  import v_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       i_in_vld;
  logic [7:0] i_in_prod_id;
  logic [2:0] i_in_cmd;
  logic [15:0] i_in_key;
  logic [7:0] i_in_size;
  logic       i_busy_r;

  logic        o_in_rdy, o_upd_vld_r;
  logic [7:0]  o_upd_prod_id_r, o_upd_size_r;
  logic [2:0]  o_upd_cmd_r;
  logic [15:0] o_upd_key_r;
  logic [2:0]  o_count_r;
  logic [15:0] o_issued_cnt_r, o_reject_cnt_r;

  logic        rdy4, vld4;
  logic [7:0]  id4, size4;
  logic [2:0]  cmd4, count4;
  logic [15:0] key4;
  logic [3:0]  issued4, reject4;

  v_upd_issue #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
    .i_in_prod_id(i_in_prod_id), .i_in_cmd(i_in_cmd), .i_in_key(i_in_key),
    .i_in_size(i_in_size), .i_busy_r(i_busy_r), .o_upd_vld_r(o_upd_vld_r),
    .o_upd_prod_id_r(o_upd_prod_id_r), .o_upd_cmd_r(o_upd_cmd_r),
    .o_upd_key_r(o_upd_key_r), .o_upd_size_r(o_upd_size_r),
    .o_count_r(o_count_r), .o_issued_cnt_r(o_issued_cnt_r),
    .o_reject_cnt_r(o_reject_cnt_r)
  );

  v_upd_issue #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_in_vld(i_in_vld), .o_in_rdy(rdy4),
    .i_in_prod_id(i_in_prod_id), .i_in_cmd(i_in_cmd), .i_in_key(i_in_key),
    .i_in_size(i_in_size), .i_busy_r(i_busy_r), .o_upd_vld_r(vld4),
    .o_upd_prod_id_r(id4), .o_upd_cmd_r(cmd4), .o_upd_key_r(key4),
    .o_upd_size_r(size4), .o_count_r(count4), .o_issued_cnt_r(issued4),
    .o_reject_cnt_r(reject4)
  );

  int n_checks;
  int n_pass;

  // Reference model: the FIFO contents as a queue plus the last bus word.
  upd_t mq[$];
  logic m_vld;
  upd_t m_bus;
  int   m_iss;
  int   m_rej;
  bit   m_acc;

  function automatic bit legalCmd(input int c);
    return (c >= 1) && (c <= 4);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_vld = 1'b0;
    m_bus = '0;
    m_iss = 0;
    m_rej = 0;
  endtask

  task automatic modelStep();
    bit   rdy;
    bit   iss;
    upd_t e;
    rdy   = (mq.size() != DEPTH);
    m_acc = i_in_vld && rdy;
    iss   = (mq.size() != 0) && !i_busy_r;
    if (iss) begin
      m_bus = mq.pop_front();
      m_vld = 1'b1;
      m_iss++;
    end else begin
      m_vld = 1'b0;
    end
    if (m_acc) begin
      if (legalCmd(int'(i_in_cmd))) begin
        e.prod_id = i_in_prod_id;
        e.cmd     = cmd_t'(i_in_cmd);
        e.key     = i_in_key;
        e.size    = i_in_size;
        mq.push_back(e);
      end else begin
        m_rej++;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model and sample #1 after the edge.
  task automatic applyStimulus(input int vld, input int id, input int cmd,
                               input int key, input int size, input int busy);
    i_in_vld     = (vld != 0);
    i_in_prod_id = 8'(id);
    i_in_cmd     = 3'(cmd);
    i_in_key     = 16'(key);
    i_in_size    = 8'(size);
    i_busy_r     = (busy != 0);
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".vld"},    int'(o_upd_vld_r),     int'(m_vld));
    checkOutput({tag, ".id"},     int'(o_upd_prod_id_r), int'(m_bus.prod_id));
    checkOutput({tag, ".cmd"},    int'(o_upd_cmd_r),     int'(m_bus.cmd));
    checkOutput({tag, ".key"},    int'(o_upd_key_r),     int'(m_bus.key));
    checkOutput({tag, ".size"},   int'(o_upd_size_r),    int'(m_bus.size));
    checkOutput({tag, ".count"},  int'(o_count_r),       mq.size());
    checkOutput({tag, ".rdy"},    int'(o_in_rdy),        int'(mq.size() != DEPTH));
    checkOutput({tag, ".issued"}, int'(o_issued_cnt_r),  sat(m_iss, 65535));
    checkOutput({tag, ".reject"}, int'(o_reject_cnt_r),  sat(m_rej, 65535));
    checkOutput({tag, ".iss4"},   int'(issued4),         sat(m_iss, 15));
    checkOutput({tag, ".rej4"},   int'(reject4),         sat(m_rej, 15));
  endtask

  typedef struct {
    int vld; int id; int cmd; int busy;
    int exp_vld; int exp_id; int exp_count; int exp_rdy; int exp_iss; int exp_rej;
  } vec_t;

  vec_t vecs[10];
  int   pend[$];
  int   obs_id[$];
  int   obs_cyc[$];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    // Rows: three back-to-back legal pushes, then 5, an illegal command, and 6.
    //            vld id  cmd busy | vld id cnt rdy iss rej
    vecs[0] = '{1,  1, 1, 0,   0,  0, 1, 1, 0, 0};
    vecs[1] = '{1,  2, 2, 0,   1,  1, 1, 1, 1, 0};
    vecs[2] = '{1,  3, 3, 0,   1,  2, 1, 1, 2, 0};
    vecs[3] = '{0,  0, 0, 0,   1,  3, 0, 1, 3, 0};
    vecs[4] = '{0,  0, 0, 0,   0,  3, 0, 1, 3, 0};
    vecs[5] = '{1,  5, 1, 0,   0,  3, 1, 1, 3, 0};
    vecs[6] = '{1, 99, 7, 0,   1,  5, 0, 1, 4, 1};
    vecs[7] = '{1,  6, 4, 0,   0,  5, 1, 1, 4, 1};
    vecs[8] = '{0,  0, 0, 0,   1,  6, 0, 1, 5, 1};
    vecs[9] = '{0,  0, 0, 0,   0,  6, 0, 1, 5, 1};

    rst_n = 1'b0;
    i_in_vld = 1'b0; i_in_prod_id = '0; i_in_cmd = '0;
    i_in_key = '0; i_in_size = '0; i_busy_r = 1'b0;
    modelReset();
    #1;
    checkOutput("reset.vld",    int'(o_upd_vld_r),    0);
    checkOutput("reset.id",     int'(o_upd_prod_id_r), 0);
    checkOutput("reset.count",  int'(o_count_r),      0);
    checkOutput("reset.issued", int'(o_issued_cnt_r), 0);
    checkOutput("reset.reject", int'(o_reject_cnt_r), 0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset.rdy", int'(o_in_rdy), 1);

    // Table-driven: ordering, latency, and the illegal-command filter.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].id, vecs[i].cmd, vecs[i].id * 3,
                    vecs[i].id, vecs[i].busy);
      checkOutput($sformatf("vec%0d.vld", i),    int'(o_upd_vld_r),     vecs[i].exp_vld);
      checkOutput($sformatf("vec%0d.id", i),     int'(o_upd_prod_id_r), vecs[i].exp_id);
      checkOutput($sformatf("vec%0d.count", i),  int'(o_count_r),       vecs[i].exp_count);
      checkOutput($sformatf("vec%0d.rdy", i),    int'(o_in_rdy),        vecs[i].exp_rdy);
      checkOutput($sformatf("vec%0d.issued", i), int'(o_issued_cnt_r),  vecs[i].exp_iss);
      checkOutput($sformatf("vec%0d.reject", i), int'(o_reject_cnt_r),  vecs[i].exp_rej);
      checkModel($sformatf("vec%0d.m", i));
    end

    // Busy: the FIFO fills, upstream is backpressured, then the FIFO drains in order.
    for (int id = 10; id < 16; id++) pend.push_back(id);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, pend[0], 1, pend[0] * 3, pend[0], 1);
      if (m_acc) void'(pend.pop_front());
      checkModel($sformatf("busy%0d", c));
      if (c == 3) begin
        checkOutput("busy.full_count", int'(o_count_r), 4);
        checkOutput("busy.full_rdy",   int'(o_in_rdy),  0);
      end
    end
    checkOutput("busy.no_issue", int'(o_upd_vld_r), 0);
    checkOutput("busy.count",    int'(o_count_r),   4);
    for (int c = 0; c < 12; c++) begin
      if (pend.size() != 0) applyStimulus(1, pend[0], 2, pend[0] * 3, pend[0], 0);
      else applyStimulus(0, 0, 0, 0, 0, 0);
      if (m_acc) void'(pend.pop_front());
      checkModel($sformatf("drain%0d", c));
      if (o_upd_vld_r) begin
        obs_id.push_back(int'(o_upd_prod_id_r));
        obs_cyc.push_back(c);
      end
    end
    checkOutput("drain.n_issued", obs_id.size(), 6);
    for (int k = 0; k < obs_id.size() && k < 6; k++) begin
      checkOutput($sformatf("drain.id%0d", k),  obs_id[k],  10 + k);
      checkOutput($sformatf("drain.cyc%0d", k), obs_cyc[k], obs_cyc[0] + k);
    end

    // Mid-stream asynchronous reset with three buffered entries.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 20 + c, 3, 1000 + c, 7, 1);
      checkModel($sformatf("prerst%0d", c));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncrst.vld",    int'(o_upd_vld_r),     0);
    checkOutput("asyncrst.id",     int'(o_upd_prod_id_r), 0);
    checkOutput("asyncrst.key",    int'(o_upd_key_r),     0);
    checkOutput("asyncrst.count",  int'(o_count_r),       0);
    checkOutput("asyncrst.issued", int'(o_issued_cnt_r),  0);
    checkOutput("asyncrst.reject", int'(o_reject_cnt_r),  0);
    modelReset();
    i_in_vld = 1'b0;
    i_busy_r = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkModel($sformatf("postrst%0d", c));
    end

    // Continuous streaming: the count settles at 1, and the counters saturate in dut4.
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 30 + c, 1 + (c % 4), c * 7, c, 0);
      checkModel($sformatf("stream%0d", c));
      checkOutput($sformatf("stream%0d.count1", c), int'(o_count_r), 1);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkModel($sformatf("tail%0d", c));
    end
    checkOutput("stream.issued16", int'(o_issued_cnt_r), 20);
    checkOutput("stream.issued4",  int'(issued4),        15);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 9) < 3));
      checkModel($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/v_upd_issue.md
Name: v_upd_issue

Overview:
- Transmitter end of the list update bus: accepts update commands from upstream over a valid/ready handshake and buffers them in a small FIFO.
- Drives the list update bus (upd_vld/prod_id/cmd/key/size) into the list engine, one command per cycle, in arrival order.
- Withholds issue while the engine reports busy, i.e. during table initialisation.
- Discards commands with illegal encodings and keeps issue and reject statistics.

Parameters:
- FIFO_DEPTH, 4, buffer entries; must be a power of two, >= 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_in_vld  in  1  upstream command valid
- o_in_rdy  out  1  upstream ready; = (count != FIFO_DEPTH), from registered count
- i_in_prod_id  in  $bits(v_pkg::id_t)  product id
- i_in_cmd  in  $bits(v_pkg::cmd_t)  command
- i_in_key  in  $bits(v_pkg::key_t)  key
- i_in_size  in  $bits(v_pkg::size_t)  size
- i_busy_r  in  1  engine busy (initialising); no issue while high
- o_upd_vld_r  out  1  update bus valid
- o_upd_prod_id_r  out  $bits(v_pkg::id_t)  update bus product id
- o_upd_cmd_r  out  $bits(v_pkg::cmd_t)  update bus command
- o_upd_key_r  out  $bits(v_pkg::key_t)  update bus key
- o_upd_size_r  out  $bits(v_pkg::size_t)  update bus size
- o_count_r  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- o_issued_cnt_r  out  CNT_W  commands issued, saturating
- o_reject_cnt_r  out  CNT_W  illegal commands discarded, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear: o_upd_vld_r=0, all o_upd_* fields=0, o_count_r=0, both counters=0, read/write pointers=0.
  - Buffered entries are lost.
  - o_in_rdy=1 once reset deasserts.
- Accept:
  - A handshake completes when i_in_vld & o_in_rdy.
  - Legal command (v_pkg::cmd_is_legal(i_in_cmd)=1): written at wr_ptr; wr_ptr increments and wraps modulo FIFO_DEPTH.
  - Illegal command: handshake still completes; the entry is not written; o_reject_cnt_r increments.
- Issue decision (each cycle): issue = (count != 0) & !i_busy_r.
  - When issue: head entry is registered onto o_upd_* with o_upd_vld_r=1 next cycle; rd_ptr increments and wraps.
  - Otherwise: o_upd_vld_r=0 next cycle; the o_upd_* data fields hold their last value.
- Latency: a legal command accepted in cycle N with an empty FIFO and busy low appears with o_upd_vld_r=1 in cycle N+2. There is no bypass path.
- Throughput: 1 command/cycle sustained; one push and one pop in the same cycle leave count unchanged.
- Full: o_in_rdy=0 whenever count==FIFO_DEPTH, including a cycle in which a pop occurs; no write-through when full.
- Busy:
  - i_busy_r is sampled only in the decision cycle.
  - A command already presented on o_upd_vld_r when busy rises counts as issued.
  - While busy, the FIFO fills, then backpressures upstream.
  - Issue resumes the cycle after busy falls, with order preserved.
- Counters:
  - o_issued_cnt_r increments on each issue.
  - Both counters saturate at all-ones and never wrap.
- o_count_r: +1 on legal push, -1 on pop, net 0 on both together.
- Ordering: strict FIFO; product ids are not reordered. Same-product hazards are resolved downstream by the engine's forwarding, so no spacing is inserted.

Decomposition:
- Shared package additions in v_pkg:
  - function cmd_is_legal(cmd_t) returning 1 for defined encodings.
  - typedef upd_t, a packed struct of prod_id, cmd, key and size, used as the FIFO entry and bus bundle.
- One sub-module: v_upd_fifo.
  - Parameterised synchronous FIFO, async active-low reset.
  - Provides push/pop, head data, registered count, full/empty.
- The top level holds the legality filter, issue register and statistics counters.

Test Plan:
- Reset release, busy=0; push 3 legal cmds (ids 1,2,3) back-to-back from cycle 0 -> o_upd_vld_r high cycles 2,3,4 with ids 1,2,3; o_issued_cnt_r=3; o_count_r returns to 0.
- busy=1; push 6 legal cmds, FIFO_DEPTH=4 -> o_in_rdy low after 4 accepts; o_count_r=4; no o_upd_vld_r. Drop busy -> 4 issues on consecutive cycles in order, then remaining 2 accepted and issued.
- Interleave illegal cmd between ids 5 and 6 -> bus shows 5 then 6 only; o_reject_cnt_r=1; illegal handshake completes with o_in_rdy=1.
- Continuous push with busy=0 for 20 cycles -> 20 issues, o_count_r stays at 1 steady state; pointers wrap; no loss or duplication.
- Assert rst_n low mid-stream with 3 entries buffered -> outputs clear immediately without a clock; after release no stale command issues; counters=0.
- CNT_W=4, 17 issues -> o_issued_cnt_r saturates at 15.
